instruction_decode: RTL and testbench

Registered instruction decoder for the thread pipeline. Splits one 32-bit instruction word into register specifiers, ALU selects, shift controls, flag and increment bits, and control strobes (SIMD, jump, stack pop, TOS write, zero-compare write, halt, illegal decode). Sits between instruction fetch and the register-read/execute stage. All outputs are registered with one-cycle latency. A sticky halt state freezes the decoder until reset.

---
 rtl/instruction_decode.sv | 120 ++++++++++++
 tb/tb_instruction_decode.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/instruction_decode.sv
// Registered instruction decoder: splits a 32-bit instruction word into register
// specifiers, shift/ALU controls and strobes. A decoded HALT freezes every output until rst.
module instruction_decode (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ins,
    output logic [3:0]  rd,
    output logic [3:0]  rs1,
    output logic [3:0]  rs0,
    output logic [9:0]  jumpAddr,
    output logic [3:0]  sh1,
    output logic        sh1dir,
    output logic [3:0]  sh2,
    output logic        sh2dir,
    output logic [2:0]  flags,
    output logic        inc,
    output logic [1:0]  alusel0,
    output logic [1:0]  alusel1,
    output logic        isSIMD,
    output logic        isJump,
    output logic        pop,
    output logic        zcmpw,
    output logic        setTOS,
    output logic        isHalted,
    output logic        idf
);

    typedef struct packed {
        logic [3:0] rd;
        logic [3:0] rs1;
        logic [3:0] rs0;
        logic [9:0] imm_sh;
        logic [2:0] flags;
        logic       inc;
        logic [1:0] alusel0;
        logic [1:0] alusel1;
        logic       is_simd;
        logic       is_jump;
        logic       pop;
        logic       zcmpw;
        logic       set_tos;
        logic       halted;
        logic       idf;
    } dec_t;

    dec_t d, q;

    logic [3:0] opcode1;
    logic [1:0] opcode2;

    assign opcode1 = ins[5:2];
    assign opcode2 = ins[1:0];

    always_comb begin
        d        = '0;
        d.rd     = ins[31:28];
        d.rs1    = ins[27:24];
        d.rs0    = ins[23:20];
        d.imm_sh = ins[19:10];
        d.inc    = ins[9];
        d.flags  = ins[8:6];
        case (opcode2)
            2'b00: begin
                d.is_simd = 1'b1;
                d.alusel0 = opcode1[1:0];
                d.alusel1 = opcode1[3:2];
            end
            2'b01: begin
                d.alusel0 = opcode1[1:0];
                d.alusel1 = opcode1[3:2];
            end
            2'b10: begin
                // jump sub-ops live in opcode1[2:0]; opcode1[3] is reserved
                if (!opcode1[3]) begin
                    d.is_jump = 1'b1;
                    d.pop     = opcode1[0];
                    d.set_tos = opcode1[1];
                    d.zcmpw   = opcode1[2];
                end else begin
                    d.idf = 1'b1;
                end
            end
            2'b11: begin
                if (opcode1 == 4'hF)
                    d.halted = 1'b1;
                else if (opcode1 != 4'h0)
                    d.idf = 1'b1;
            end
        endcase
    end

    // q.halted is the sticky halt flag; once set, nothing reloads until rst
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q <= '0;
        else if (!q.halted)
            q <= d;
    end

    assign rd       = q.rd;
    assign rs1      = q.rs1;
    assign rs0      = q.rs0;
    assign jumpAddr = q.imm_sh;
    assign sh1      = q.imm_sh[3:0];
    assign sh1dir   = q.imm_sh[4];
    assign sh2      = q.imm_sh[8:5];
    assign sh2dir   = q.imm_sh[9];
    assign flags    = q.flags;
    assign inc      = q.inc;
    assign alusel0  = q.alusel0;
    assign alusel1  = q.alusel1;
    assign isSIMD   = q.is_simd;
    assign isJump   = q.is_jump;
    assign pop      = q.pop;
    assign zcmpw    = q.zcmpw;
    assign setTOS   = q.set_tos;
    assign isHalted = q.halted;
    assign idf      = q.idf;

endmodule

// File: tb/tb_instruction_decode.sv
// Bench for instruction_decode: directed test-plan steps plus random instructions
// checked against a field-level reference model with sticky-halt tracking.
module tb_instruction_decode;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ins;
    logic [3:0]  rd, rs1, rs0, sh1, sh2;
    logic [9:0]  jumpAddr;
    logic        sh1dir, sh2dir, inc;
    logic [2:0]  flags;
    logic [1:0]  alusel0, alusel1;
    logic        isSIMD, isJump, pop, zcmpw, setTOS, isHalted, idf;

    instruction_decode dut (
        .clk(clk), .rst(rst), .ins(ins),
        .rd(rd), .rs1(rs1), .rs0(rs0), .jumpAddr(jumpAddr),
        .sh1(sh1), .sh1dir(sh1dir), .sh2(sh2), .sh2dir(sh2dir),
        .flags(flags), .inc(inc), .alusel0(alusel0), .alusel1(alusel1),
        .isSIMD(isSIMD), .isJump(isJump), .pop(pop), .zcmpw(zcmpw),
        .setTOS(setTOS), .isHalted(isHalted), .idf(idf)
    );

    always #5 clk = ~clk;

    typedef struct {
        int rd, rs1, rs0, jaddr, sh1, sh1dir, sh2, sh2dir, flags, inc;
        int alusel0, alusel1, simd, jump, pop, zcmpw, settos, halted, idf;
    } exp_t;

    exp_t exp_q;
    bit   m_halt;
    int   total = 0;
    int   bad   = 0;

    function automatic exp_t zero_exp();
        exp_t e;
        e = '{default: 0};
        return e;
    endfunction

    // Decode straight from the field layout using shifts and modulo arithmetic.
    function automatic exp_t model(input logic [31:0] w);
        exp_t e;
        int   imm, op1, op2;
        e      = zero_exp();
        op2    = int'(w % 4);
        op1    = int'((w / 4) % 16);
        imm    = int'((w >> 10) % 1024);
        e.rd   = int'(w >> 28);
        e.rs1  = int'((w >> 24) % 16);
        e.rs0  = int'((w >> 20) % 16);
        e.jaddr  = imm;
        e.sh1    = imm % 16;
        e.sh1dir = (imm / 16) % 2;
        e.sh2    = (imm / 32) % 16;
        e.sh2dir = imm / 512;
        e.flags  = int'((w >> 6) % 8);
        e.inc    = int'((w >> 9) % 2);
        if (op2 <= 1) begin
            e.simd    = (op2 == 0) ? 1 : 0;
            e.alusel0 = op1 % 4;
            e.alusel1 = op1 / 4;
        end else if (op2 == 2) begin
            if (op1 < 8) begin
                e.jump   = 1;
                e.pop    = op1 % 2;
                e.settos = (op1 / 2) % 2;
                e.zcmpw  = (op1 / 4) % 2;
            end else begin
                e.idf = 1;
            end
        end else begin
            if (op1 == 15)     e.halted = 1;
            else if (op1 != 0) e.idf = 1;
        end
        return e;
    endfunction

    task automatic chk(input string tag, input int obs, input int want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s got=%0h want=%0h", tag, obs, want);
        end
    endtask

    task automatic check_all();
        chk("rd", int'(rd), exp_q.rd);
        chk("rs1", int'(rs1), exp_q.rs1);
        chk("rs0", int'(rs0), exp_q.rs0);
        chk("jumpAddr", int'(jumpAddr), exp_q.jaddr);
        chk("sh1", int'(sh1), exp_q.sh1);
        chk("sh1dir", int'(sh1dir), exp_q.sh1dir);
        chk("sh2", int'(sh2), exp_q.sh2);
        chk("sh2dir", int'(sh2dir), exp_q.sh2dir);
        chk("flags", int'(flags), exp_q.flags);
        chk("inc", int'(inc), exp_q.inc);
        chk("alusel0", int'(alusel0), exp_q.alusel0);
        chk("alusel1", int'(alusel1), exp_q.alusel1);
        chk("isSIMD", int'(isSIMD), exp_q.simd);
        chk("isJump", int'(isJump), exp_q.jump);
        chk("pop", int'(pop), exp_q.pop);
        chk("zcmpw", int'(zcmpw), exp_q.zcmpw);
        chk("setTOS", int'(setTOS), exp_q.settos);
        chk("isHalted", int'(isHalted), exp_q.halted);
        chk("idf", int'(idf), exp_q.idf);
    endtask

    // Present w for one rising edge, advance the model, compare after the edge.
    task automatic step(input logic [31:0] w);
        @(negedge clk);
        ins = w;
        @(posedge clk);
        if (!m_halt) begin
            exp_q  = model(w);
            m_halt = (exp_q.halted != 0);
        end
        #1;
        check_all();
    endtask

    // Assert rst between edges and check the asynchronous clear before any edge.
    task automatic reset_mid();
        @(posedge clk);
        #2 rst = 1'b1;
        exp_q  = zero_exp();
        m_halt = 1'b0;
        #1;
        check_all();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] w;
        int          halt_age;
        rst    = 1'b1;
        ins    = 32'h0;
        exp_q  = zero_exp();
        m_halt = 1'b0;
        #2;
        check_all();
        @(negedge clk);
        rst = 1'b0;

        step(32'h0000_0000);
        chk("tp_zero_simd", int'(isSIMD), 1);

        step(32'hA124_8C80);
        chk("tp_rd", int'(rd), 10);
        chk("tp_jaddr", int'(jumpAddr), 'h123);
        chk("tp_sh2", int'(sh2), 9);
        chk("tp_sh1", int'(sh1), 3);
        chk("tp_flags", int'(flags), 2);

        step(32'h0000_0035);
        chk("tp_scalar_sel0", int'(alusel0), 1);
        chk("tp_scalar_sel1", int'(alusel1), 3);

        step(32'h000F_FC1E);
        chk("tp_jump", int'(isJump), 1);
        chk("tp_jump_addr", int'(jumpAddr), 'h3FF);

        step(32'h0000_0022);
        chk("tp_jump_illegal", int'(idf), 1);

        step(32'h0000_0017);
        chk("tp_sys_idf", int'(idf), 1);

        step(32'h0000_0003);

        step(32'h1234_56FF);
        chk("tp_halt", int'(isHalted), 1);
        step(32'h0000_0000);
        step(32'hFFFF_FFFD);
        step(32'h5A5A_5A5A);
        chk("tp_halt_hold_rd", int'(rd), 1);

        reset_mid();
        step(32'hC300_0004);
        chk("tp_after_reset_rd", int'(rd), 12);

        halt_age = 0;
        for (int i = 0; i < 400; i++) begin
            w = $urandom;
            if ($urandom_range(0, 7) == 0) w[1:0] = 2'b11;
            if ($urandom_range(0, 31) == 0) w[5:0] = 6'h3F;
            step(w);
            if (m_halt) begin
                halt_age++;
                if (halt_age > 2) begin
                    reset_mid();
                    halt_age = 0;
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
